// File: rtl/mem_stage_pipe.sv
// EX/MEM and MEM/WB pipeline registers plus the data-memory access stage.
// A variable-latency memory access holds EX/MEM and bubbles MEM/WB until it completes.
module mem_stage_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_RegWrite,
  input  logic        ex_MemRead,
  input  logic        ex_MemWrite,
  input  logic        ex_MemtoReg,
  input  logic [4:0]  ex_mux1_out,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        EX_MEM_RegWrite,
  output logic [4:0]  EX_MEM_mux1_out,
  output logic [31:0] EX_MEM_alu_result,
  output logic        MEM_WB_RegWrite,
  output logic [4:0]  MEM_WB_mux1_out,
  output logic [31:0] MEM_WB_wdata,
  output logic [15:0] stall_cycles
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        memto_reg;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] sdata;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } memwb_t;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  exmem_t exm;
  memwb_t mwb;
  state_t state, state_nxt;
  logic   pending;

  assign pending = exm.valid & (exm.mem_read | exm.mem_write);

  // Read+write together is illegal and resolves to a load.
  assign dmem_req   = pending;
  assign dmem_we    = exm.mem_write & ~exm.mem_read;
  assign dmem_addr  = exm.alu;
  assign dmem_wdata = exm.sdata;
  assign mem_stall  = dmem_req & ~dmem_ready;

  assign EX_MEM_RegWrite   = exm.reg_write & exm.valid;
  assign EX_MEM_mux1_out   = exm.rd;
  assign EX_MEM_alu_result = exm.alu;

  assign MEM_WB_RegWrite = mwb.reg_write;
  assign MEM_WB_mux1_out = mwb.rd;
  assign MEM_WB_wdata    = mwb.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pending && !dmem_ready) state_nxt = WAIT;
      WAIT: if (dmem_ready)             state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exm <= '0;
    end else if (!mem_stall) begin
      exm.valid     <= ex_valid;
      exm.reg_write <= ex_RegWrite;
      exm.mem_read  <= ex_MemRead;
      exm.mem_write <= ex_MemWrite;
      exm.memto_reg <= ex_MemtoReg;
      exm.rd        <= ex_mux1_out;
      exm.alu       <= ex_alu_result;
      exm.sdata     <= ex_store_data;
    end
  end

  // A stalled cycle drops a bubble into MEM/WB; rd/wdata keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mwb <= '0;
    end else if (mem_stall) begin
      mwb.reg_write <= 1'b0;
    end else begin
      mwb.reg_write <= exm.reg_write & exm.valid;
      mwb.rd        <= exm.rd;
      mwb.wdata     <= exm.memto_reg ? dmem_rdata : exm.alu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               stall_cycles <= '0;
    else if (mem_stall && stall_cycles != '1) stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: ALU op, wait-state load, store, back-to-back
// loads, reset during a pending access, and a bubble.
module tb_mem_stage_pipe;
  logic        clk, rst_n;
  logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic [4:0]  ex_mux1_out;
  logic [31:0] ex_alu_result, ex_store_data;
  logic        dmem_req, dmem_we, dmem_ready, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic [4:0]  EX_MEM_mux1_out, MEM_WB_mux1_out;
  logic [31:0] EX_MEM_alu_result, MEM_WB_wdata;
  logic [15:0] stall_cycles;

  int checks = 0;
  int fails  = 0;

  mem_stage_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_mux1_out(ex_mux1_out), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_mux1_out(EX_MEM_mux1_out),
    .EX_MEM_alu_result(EX_MEM_alu_result),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_mux1_out(MEM_WB_mux1_out),
    .MEM_WB_wdata(MEM_WB_wdata), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic m2r, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] sd);
    ex_valid = v; ex_RegWrite = rw; ex_MemRead = mr; ex_MemWrite = mw;
    ex_MemtoReg = m2r; ex_mux1_out = rd; ex_alu_result = alu; ex_store_data = sd;
  endtask

  task automatic bubble;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h0;
    #1;
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_mem_stall", mem_stall, 0);
    chk("rst_exmem_rw", EX_MEM_RegWrite, 0);
    chk("rst_memwb_rw", MEM_WB_RegWrite, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    #21 rst_n = 1'b1;

    // ALU op
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'h0);
    tick();
    bubble();
    settle();
    chk("alu_exmem_rw", EX_MEM_RegWrite, 1);
    chk("alu_exmem_rd", EX_MEM_mux1_out, 5);
    chk("alu_exmem_res", EX_MEM_alu_result, 32'h1234);
    chk("alu_stall", mem_stall, 0);
    tick();
    chk("alu_memwb_wdata", MEM_WB_wdata, 32'h1234);
    chk("alu_memwb_rw", MEM_WB_RegWrite, 1);
    chk("alu_memwb_rd", MEM_WB_mux1_out, 5);

    // Load with three wait cycles
    dmem_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h40, 32'h0);
    tick();
    bubble();
    settle();
    chk("ld_req", dmem_req, 1);
    chk("ld_we", dmem_we, 0);
    chk("ld_addr", dmem_addr, 32'h40);
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_hi", mem_stall, 1);
      chk("ld_memwb_rw_lo", MEM_WB_RegWrite, 0);
      tick();
    end
    chk("ld_stall_cycles", stall_cycles, 3);
    dmem_ready = 1'b1;
    dmem_rdata = 32'hDEADBEEF;
    settle();
    chk("ld_stall_released", mem_stall, 0);
    tick();
    chk("ld_memwb_wdata", MEM_WB_wdata, 32'hDEADBEEF);
    chk("ld_memwb_rd", MEM_WB_mux1_out, 8);
    chk("ld_memwb_rw", MEM_WB_RegWrite, 1);
    chk("ld_stall_cycles_hold", stall_cycles, 3);
    dmem_rdata = 32'h0;

    // Store, zero-wait
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h80, 32'hA5A5A5A5);
    tick();
    bubble();
    settle();
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_addr", dmem_addr, 32'h80);
    chk("st_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("st_stall", mem_stall, 0);
    tick();
    chk("st_req_done", dmem_req, 0);
    chk("st_memwb_rw", MEM_WB_RegWrite, 0);
    chk("st_stall_cycles", stall_cycles, 3);

    // Back-to-back zero-wait loads
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h100, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd10, 32'h104, 32'h0);
    dmem_rdata = 32'h11111111;
    settle();
    chk("b2b_req0", dmem_req, 1);
    chk("b2b_addr0", dmem_addr, 32'h100);
    chk("b2b_stall0", mem_stall, 0);
    tick();
    bubble();
    dmem_rdata = 32'h22222222;
    settle();
    chk("b2b_req1", dmem_req, 1);
    chk("b2b_addr1", dmem_addr, 32'h104);
    chk("b2b_wb0_rd", MEM_WB_mux1_out, 9);
    chk("b2b_wb0_data", MEM_WB_wdata, 32'h11111111);
    chk("b2b_wb0_rw", MEM_WB_RegWrite, 1);
    tick();
    chk("b2b_wb1_rd", MEM_WB_mux1_out, 10);
    chk("b2b_wb1_data", MEM_WB_wdata, 32'h22222222);
    chk("b2b_wb1_rw", MEM_WB_RegWrite, 1);
    chk("b2b_req_done", dmem_req, 0);
    chk("b2b_stall_cycles", stall_cycles, 3);

    // Reset asserted while a load is waiting
    dmem_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h200, 32'h0);
    tick();
    bubble();
    settle();
    chk("rw_stall", mem_stall, 1);
    chk("rw_exmem_rw", EX_MEM_RegWrite, 1);
    tick();
    chk("rw_stall_cycles", stall_cycles, 4);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_req", dmem_req, 0);
    chk("rw_rst_stall", mem_stall, 0);
    chk("rw_rst_exmem_rw", EX_MEM_RegWrite, 0);
    chk("rw_rst_memwb_rw", MEM_WB_RegWrite, 0);
    chk("rw_rst_stall_cycles", stall_cycles, 0);
    #1 rst_n = 1'b1;
    dmem_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h77, 32'h0);
    tick();
    bubble();
    settle();
    chk("rw_new_exmem_rw", EX_MEM_RegWrite, 1);
    chk("rw_new_exmem_res", EX_MEM_alu_result, 32'h77);
    tick();
    chk("rw_new_memwb_data", MEM_WB_wdata, 32'h77);
    chk("rw_new_memwb_rw", MEM_WB_RegWrite, 1);
    chk("rw_new_stall_cycles", stall_cycles, 0);

    // Bubble carrying load/write controls
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h300, 32'h0);
    tick();
    settle();
    chk("bub_req", dmem_req, 0);
    chk("bub_exmem_rw", EX_MEM_RegWrite, 0);
    chk("bub_stall", mem_stall, 0);
    tick();
    chk("bub_memwb_rw", MEM_WB_RegWrite, 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
